// File: rtl/rx_att_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rx_att_pkg
// Description : Shared types for the receive-attenuator write scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package rx_att_pkg;

    localparam int NUM_CH = 3;

    typedef logic [1:0] ch_idx_t;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SCAN    = 3'd1,
        S_GATE    = 3'd2,
        S_ISSUE   = 3'd3,
        S_WAIT_HI = 3'd4,
        S_WAIT_LO = 3'd5,
        S_FAIL    = 3'd6,
        S_DONE    = 3'd7
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rx_att_sched.sv
`default_nettype none
// ============================================================================
// Module      : rx_att_sched
// Description : Writes changed DS3502 wiper codes through one shared engine,
//               one channel at a time, gated by tr, with retry and error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_att_sched
    import rx_att_pkg::*;
#(
    parameter int START_TO  = 16,
    parameter int DONE_TO   = 65535,
    parameter int MAX_RETRY = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] ch1_att,
    input  logic [7:0] ch2_att,
    input  logic [7:0] ch3_att,
    input  logic       tr,
    input  logic       eng_busy,
    input  logic       eng_nack,
    output logic       eng_load,
    output logic [7:0] eng_r,
    output logic [1:0] eng_sel,
    output logic       busy,
    output logic       done,
    output logic [2:0] err
);

    state_t              r_state;
    logic [7:0]          r_snap   [NUM_CH];
    logic [7:0]          r_shadow [NUM_CH];
    logic                r_shadow_valid;
    logic                r_pend;
    logic [NUM_CH-1:0]   r_mask;
    ch_idx_t             r_ch;
    logic [1:0]          r_retry;
    logic [15:0]         r_timer;
    logic                r_eng_load;
    logic [7:0]          r_eng_r;
    logic [1:0]          r_eng_sel;
    logic                r_busy;
    logic                r_done;
    logic [NUM_CH-1:0]   r_err;

    logic [7:0]          w_in [NUM_CH];
    logic                w_sv_eff;
    logic [NUM_CH-1:0]   w_new_mask;
    logic                w_snap;

    function automatic ch_idx_t f_lowest(input logic [NUM_CH-1:0] m);
        ch_idx_t idx;
        idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i]) idx = ch_idx_t'(i);
        end
        return idx;
    endfunction

    // In DONE the shadow-valid update lands on the same edge as a follow-on
    // snapshot, so the change mask must see the value being written.
    always_comb begin
        w_in[0]  = ch1_att;
        w_in[1]  = ch2_att;
        w_in[2]  = ch3_att;
        w_sv_eff = r_shadow_valid | ((r_state == S_DONE) && (r_err == '0));
        for (int i = 0; i < NUM_CH; i++) begin
            w_new_mask[i] = ~w_sv_eff | (w_in[i] != r_shadow[i]);
        end
    end

    assign w_snap = ((r_state == S_IDLE) && load) ||
                    ((r_state == S_DONE) && (r_pend || load));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_shadow_valid <= 1'b0;
            r_pend         <= 1'b0;
            r_mask         <= '0;
            r_ch           <= '0;
            r_retry        <= '0;
            r_timer        <= '0;
            r_eng_load     <= 1'b0;
            r_eng_r        <= '0;
            r_eng_sel      <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_err          <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_snap[i]   <= '0;
                r_shadow[i] <= '0;
            end
        end else begin
            r_eng_load <= 1'b0;
            r_done     <= 1'b0;
            if (r_timer != 16'hFFFF) r_timer <= r_timer + 16'd1;
            if (load && (r_state != S_IDLE) && (r_state != S_DONE)) r_pend <= 1'b1;

            if (w_snap) begin
                for (int i = 0; i < NUM_CH; i++) r_snap[i] <= w_in[i];
                r_mask <= w_new_mask;
                r_err  <= '0;
            end

            case (r_state)
                S_IDLE: begin
                    if (load) begin
                        r_busy  <= 1'b1;
                        r_state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (r_mask == '0) begin
                        r_state <= S_DONE;
                    end else begin
                        r_ch    <= f_lowest(r_mask);
                        r_retry <= '0;
                        r_state <= S_GATE;
                    end
                end
                S_GATE: begin
                    if (!tr) begin
                        r_eng_sel  <= r_ch;
                        r_eng_r    <= r_snap[r_ch];
                        r_eng_load <= 1'b1;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_timer <= '0;
                    r_state <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    if (eng_busy) begin
                        r_timer <= '0;
                        r_state <= S_WAIT_LO;
                    end else if ({16'd0, r_timer} > 32'(START_TO)) begin
                        r_state <= S_FAIL;
                    end
                end
                S_WAIT_LO: begin
                    if (!eng_busy) begin
                        if (eng_nack) begin
                            r_state <= S_FAIL;
                        end else begin
                            r_shadow[r_ch] <= r_snap[r_ch];
                            r_mask[r_ch]   <= 1'b0;
                            r_state        <= S_SCAN;
                        end
                    end else if ({16'd0, r_timer} > 32'(DONE_TO)) begin
                        r_state <= S_FAIL;
                    end
                end
                S_FAIL: begin
                    if ({30'd0, r_retry} < 32'(MAX_RETRY)) begin
                        r_retry <= r_retry + 2'd1;
                        r_state <= S_GATE;
                    end else begin
                        r_err[r_ch]  <= 1'b1;
                        r_mask[r_ch] <= 1'b0;
                        r_state      <= S_SCAN;
                    end
                end
                S_DONE: begin
                    r_done <= 1'b1;
                    if (r_err == '0) r_shadow_valid <= 1'b1;
                    // A load landing on this very cycle is merged with any pending one.
                    if (r_pend || load) begin
                        r_pend  <= 1'b0;
                        r_state <= S_SCAN;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign eng_load = r_eng_load;
    assign eng_r    = r_eng_r;
    assign eng_sel  = r_eng_sel;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_rx_att_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_att_sched
// Description : Scoreboard bench for rx_att_sched with a behavioural engine.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_att_sched;

    localparam int MAXR = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [7:0] ch1_att, ch2_att, ch3_att;
    logic       tr;
    logic       eng_busy, eng_nack;
    logic       eng_load;
    logic [7:0] eng_r;
    logic [1:0] eng_sel;
    logic       busy, done;
    logic [2:0] err;

    rx_att_sched #(.START_TO(16), .DONE_TO(65535), .MAX_RETRY(MAXR)) dut (
        .clk(clk), .rst(rst), .load(load),
        .ch1_att(ch1_att), .ch2_att(ch2_att), .ch3_att(ch3_att),
        .tr(tr), .eng_busy(eng_busy), .eng_nack(eng_nack),
        .eng_load(eng_load), .eng_r(eng_r), .eng_sel(eng_sel),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [1:0] sel; logic [7:0] r; } wr_t;
    typedef struct packed { logic [2:0] err; logic busy; logic [31:0] wcnt; } dn_t;

    wr_t exp_wq[$];
    dn_t exp_dq[$];
    wr_t mon_w;
    dn_t mon_d;

    int vectors = 0, miscompares = 0;
    int cyc = 0;
    int n_el = 0, n_done = 0;
    int first_el_cyc = -1, last_done_cyc = -1, load_cyc = 0;
    int tr_fall_cyc = -1;
    int tr_mode = 0;
    logic tr_s = 1'b0;
    logic [2:0] nack_mask = 3'b000;
    logic eng_dead = 1'b0;

    logic [7:0] m_shadow [3];
    logic       m_sv;
    int         m_wtotal;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        tr_s <= tr;
    end

    // tr driver: 0 = low, 1 = high, 2 = random
    initial begin
        logic nt;
        tr = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            nt = (tr_mode == 1) ? 1'b1 : (tr_mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
            if (tr && !nt) tr_fall_cyc = cyc;
            tr = nt;
        end
    end

    // Behavioural DS3502 write engine
    initial begin
        int   hold;
        logic nk;
        eng_busy = 1'b0;
        eng_nack = 1'b0;
        forever begin
            @(negedge clk);
            eng_nack = 1'b0;
            if (rst && eng_load && !eng_dead) begin
                hold     = 2 + $urandom_range(0, 4);
                nk       = nack_mask[eng_sel];
                eng_busy = 1'b1;
                repeat (hold) @(negedge clk);
                eng_busy = 1'b0;
                eng_nack = nk;
            end
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst) begin
            if (eng_load) begin
                n_el++;
                if (first_el_cyc < 0) first_el_cyc = cyc;
                chk("no_load_under_tr", {31'd0, tr_s}, 32'd0);
                if (exp_wq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_eng_load: got sel=%0d r=%0h expected none", eng_sel, eng_r);
                end else begin
                    mon_w = exp_wq.pop_front();
                    chk("eng_sel", {30'd0, eng_sel}, {30'd0, mon_w.sel});
                    chk("eng_r", {24'd0, eng_r}, {24'd0, mon_w.r});
                end
            end
            if (done) begin
                n_done++;
                last_done_cyc = cyc;
                if (exp_dq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_done: got done=1 expected none");
                end else begin
                    mon_d = exp_dq.pop_front();
                    chk("err_at_done", {29'd0, err}, {29'd0, mon_d.err});
                    chk("busy_at_done", {31'd0, busy}, {31'd0, mon_d.busy});
                    chk("writes_at_done", n_el, mon_d.wcnt);
                end
            end
        end
    end

    // Reference model: a pass writes every changed (or never-validated) channel;
    // a failing channel costs MAXR+1 attempts and keeps its old shadow.
    task automatic model_pass(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                              input logic pend_next);
        logic [7:0] v [3];
        logic [2:0] e;
        logic       fails;
        int         att;
        v[0] = a; v[1] = b; v[2] = c;
        e = 3'b000;
        for (int i = 0; i < 3; i++) begin
            if (!m_sv || v[i] != m_shadow[i]) begin
                fails = eng_dead || nack_mask[i];
                att   = fails ? MAXR + 1 : 1;
                for (int k = 0; k < att; k++) begin
                    exp_wq.push_back('{sel: 2'(i), r: v[i]});
                    m_wtotal++;
                end
                if (fails) e[i] = 1'b1;
                else m_shadow[i] = v[i];
            end
        end
        if (e == 3'b000) m_sv = 1'b1;
        exp_dq.push_back('{err: pend_next ? 3'b000 : e, busy: pend_next, wcnt: 32'(m_wtotal)});
    endtask

    task automatic set_in(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        ch1_att = a; ch2_att = b; ch3_att = c;
    endtask

    function automatic logic [7:0] rnd_code();
        return 8'h40 + 8'($urandom_range(0, 3));
    endfunction

    task automatic start_pass(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                              input int npend, output int target);
        logic [7:0] pa, pb, pc;
        target = n_done + 1 + ((npend > 0) ? 1 : 0);
        model_pass(a, b, c, npend > 0);
        set_in(a, b, c);
        load_cyc = cyc;
        load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        pa = a; pb = b; pc = c;
        for (int k = 0; k < npend; k++) begin
            pa = rnd_code(); pb = rnd_code(); pc = rnd_code();
            set_in(pa, pb, pc);
            load = 1'b1;
            @(posedge clk); #1;
            load = 1'b0;
        end
        if (npend > 0) model_pass(pa, pb, pc, 1'b0);
    endtask

    task automatic wait_done(input int target, input int budget);
        int t;
        t = 0;
        while (n_done < target && t < budget) begin
            @(posedge clk); #1;
            t++;
        end
        if (n_done < target) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: got %0d done pulses expected %0d", n_done, target);
        end
        repeat (2) @(posedge clk);
        #1;
        chk("writes_consumed", exp_wq.size(), 32'd0);
    endtask

    task automatic run_pass(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                            input int npend, input int budget);
        int target;
        start_pass(a, b, c, npend, target);
        wait_done(target, budget);
    endtask

    task automatic do_reset();
        int t;
        rst = 1'b0;
        load = 1'b0;
        tr_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        t = 0;
        while (eng_busy && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        exp_wq.delete();
        exp_dq.delete();
        m_sv = 1'b0;
        for (int i = 0; i < 3; i++) m_shadow[i] = 8'h00;
        m_wtotal = n_el;
        rst = 1'b1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int tgt;
        rst = 1'b0;
        load = 1'b0;
        set_in(8'h00, 8'h00, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        @(posedge clk); #1;

        chk("rst_eng_load", {31'd0, eng_load}, 32'd0);
        chk("rst_eng_r", {24'd0, eng_r}, 32'd0);
        chk("rst_eng_sel", {30'd0, eng_sel}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {29'd0, err}, 32'd0);

        // First pass writes all three channels in order
        first_el_cyc = -1;
        run_pass(8'h10, 8'h20, 8'h30, 0, 500);
        chk("load_to_eng_load", first_el_cyc - load_cyc, 32'd3);

        // Only ch2 changed
        run_pass(8'h10, 8'h21, 8'h30, 0, 500);

        // Identical load: no writes, done three cycles after load
        run_pass(8'h10, 8'h21, 8'h30, 0, 500);
        chk("done_latency_nochange", last_done_cyc - load_cyc, 32'd3);

        // tr held high for 100 cycles delays the first write
        tr_mode = 1;
        repeat (2) @(posedge clk);
        #1;
        first_el_cyc = -1;
        start_pass(8'h10, 8'h21, 8'h33, 0, tgt);
        repeat (100) @(posedge clk);
        #1;
        tr_mode = 0;
        wait_done(tgt, 500);
        chk("tr_release_gap", first_el_cyc - tr_fall_cyc, 32'd1);

        // ch1 always NACKs; shadow stays invalid so the repeat rewrites all
        do_reset();
        nack_mask = 3'b001;
        run_pass(8'h10, 8'h20, 8'h30, 0, 2000);
        run_pass(8'h10, 8'h20, 8'h30, 0, 2000);
        nack_mask = 3'b000;

        // Engine never answers: start timeout on every attempt
        do_reset();
        eng_dead = 1'b1;
        run_pass(8'h01, 8'h02, 8'h03, 0, 3000);
        eng_dead = 1'b0;

        // Loads during a pass merge into one extra pass with the newest values
        run_pass(8'h50, 8'h51, 8'h52, 2, 3000);
        run_pass(8'h50, 8'h51, 8'h52, 1, 3000);

        // Mid-pass reset invalidates the shadow
        start_pass(8'h60, 8'h61, 8'h62, 0, tgt);
        repeat (6) @(posedge clk);
        #1;
        do_reset();
        @(posedge clk); #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_eng_load", {31'd0, eng_load}, 32'd0);
        run_pass(8'h60, 8'h61, 8'h62, 0, 2000);

        // Randomised passes
        for (int it = 0; it < 25; it++) begin
            nack_mask = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            tr_mode   = ($urandom_range(0, 2) == 0) ? 2 : 0;
            run_pass(rnd_code(), rnd_code(), rnd_code(), $urandom_range(0, 2), 4000);
        end
        nack_mask = 3'b000;
        tr_mode = 0;
        repeat (4) @(posedge clk);
        #1;
        chk("final_dones_consumed", exp_dq.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
